// File: rtl/asip_isa_pkg.sv
// ----------------------------------------------------------------------------
// asip_isa_pkg
// Instruction-set definitions for the vector ASIP decode stage.
//   - Opcode constants OP_LOSC..OP_LMEM (instr[15:12])
//   - wrFromT: selector for the write-back source of the destination register
//   - PcWriteEn one-hot branch encodings
//   - decodeT: execute-stage control bundle produced by decodeInstr()
//   - srcUseT: which register fields an opcode reads, and from which file
// Instruction format: [15:12] opcode, [11:8] reg A / dest, [7:4] reg B,
// [7:0] immediate (overlaps reg B).
// ----------------------------------------------------------------------------
package asip_isa_pkg;

  localparam int ISA_RF_AW = 4;

  localparam logic [3:0] OP_LOSC  = 4'h0;
  localparam logic [3:0] OP_XOR   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_MUL   = 4'h4;
  localparam logic [3:0] OP_RSHF  = 4'h5;
  localparam logic [3:0] OP_LSHF  = 4'h6;
  localparam logic [3:0] OP_INC   = 4'h7;
  localparam logic [3:0] OP_JE    = 4'h8;
  localparam logic [3:0] OP_JNE   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_ILL_B = 4'hB;
  localparam logic [3:0] OP_SVPIX = 4'hC;
  localparam logic [3:0] OP_LOPIX = 4'hD;
  localparam logic [3:0] OP_ILL_E = 4'hE;
  localparam logic [3:0] OP_LMEM  = 4'hF;

  typedef enum logic [1:0] {
    WR_FROM_MEM = 2'd0,
    WR_FROM_ALU = 2'd1,
    WR_FROM_IMM = 2'd2
  } wrFromT;

  localparam logic [2:0] PCW_NONE = 3'b000;
  localparam logic [2:0] PCW_JMP  = 3'b100;
  localparam logic [2:0] PCW_JE   = 3'b010;
  localparam logic [2:0] PCW_JNE  = 3'b001;

  typedef struct packed {
    logic                 memoryWrite;
    wrFromT               writeRegFrom;
    logic [ISA_RF_AW-1:0] regToWrite;
    logic [ISA_RF_AW-1:0] regSrcA;
    logic [ISA_RF_AW-1:0] regSrcB;
    logic [7:0]           immediate;
    logic                 regWriteEnSc;
    logic                 regWriteEnVec;
    logic                 overWriteNz;
    logic [2:0]           pcWriteEn;
    logic [2:0]           aluOpCode;
    logic                 illegal;
  } decodeT;

  // Register fields actually read by an instruction; used for RAW checks.
  typedef struct packed {
    logic scA;
    logic scB;
    logic vecA;
    logic vecB;
  } srcUseT;

  // Pure combinational decode of one instruction word. Field extraction is
  // unconditional; only enables and selectors depend on the opcode.
  function automatic decodeT decodeInstr(input logic [15:0] instr);
    decodeT d;
    d            = '0;
    d.regToWrite = instr[11:8];
    d.regSrcA    = instr[11:8];
    d.regSrcB    = instr[7:4];
    d.immediate  = instr[7:0];
    case (instr[15:12])
      OP_LOSC: begin
        d.regWriteEnSc = 1'b1;
        d.writeRegFrom = WR_FROM_IMM;
      end
      OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_RSHF, OP_LSHF: begin
        d.aluOpCode     = instr[14:12];
        d.regWriteEnVec = 1'b1;
        d.writeRegFrom  = WR_FROM_ALU;
        d.overWriteNz   = 1'b1;
      end
      OP_INC: begin
        d.aluOpCode    = 3'd7;
        d.regWriteEnSc = 1'b1;
        d.writeRegFrom = WR_FROM_ALU;
        d.overWriteNz  = 1'b1;
      end
      OP_JE:    d.pcWriteEn = PCW_JE;
      OP_JNE:   d.pcWriteEn = PCW_JNE;
      OP_JMP:   d.pcWriteEn = PCW_JMP;
      OP_SVPIX: d.memoryWrite = 1'b1;
      OP_LOPIX: begin
        d.regWriteEnVec = 1'b1;
        d.writeRegFrom  = WR_FROM_MEM;
      end
      OP_LMEM: begin
        d.regWriteEnSc = 1'b1;
        d.writeRegFrom = WR_FROM_MEM;
      end
      OP_ILL_B, OP_ILL_E: d.illegal = 1'b1;
      default:            d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // Source-operand usage per opcode:
  //   vector ALU ops read vA, vB; inc reads sA; svpix stores vA to address sB;
  //   lopix/lmem load from address sB; losc and branches read no registers.
  function automatic srcUseT decodeSrcUse(input logic [3:0] opcode);
    srcUseT u;
    u = '0;
    case (opcode)
      OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_RSHF, OP_LSHF: begin
        u.vecA = 1'b1;
        u.vecB = 1'b1;
      end
      OP_INC:   u.scA = 1'b1;
      OP_SVPIX: begin
        u.vecA = 1'b1;
        u.scB  = 1'b1;
      end
      OP_LOPIX, OP_LMEM: u.scB = 1'b1;
      default:  u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// One pending bit per register of a 2**REG_AW entry register file.
// A bit is set when an instruction writing that register issues to execute
// and cleared when its writeback retires.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   setEn / setReg      mark setReg pending
//   clrEn / clrReg      release clrReg
//   pending             current pending vector (registered)
// ----------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int REG_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   setEn,
  input  logic [REG_AW-1:0]      setReg,
  input  logic                   clrEn,
  input  logic [REG_AW-1:0]      clrReg,
  output logic [(2**REG_AW)-1:0] pending
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0] pendNext;

  // Clear first, then set: a register re-issued in the same cycle its older
  // writer retires must stay pending for the new writer.
  always_comb begin
    pendNext = pending;
    if (clrEn) pendNext[clrReg] = 1'b0;
    if (setEn) pendNext[setReg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pendNext;
  end

endmodule

// File: rtl/decode_stage_piped.sv
// ----------------------------------------------------------------------------
// decode_stage_piped
// Registered decode stage of the vector ASIP. One 16-bit instruction per
// cycle is decoded and captured in an ID/EX register with valid/ready
// handshake. Scalar and vector scoreboards plus an in-flight NZ-writer
// counter stall fetch on hazards; flush kills the held instruction.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_instr/in_pc  fetch side
//   flush                           execute redirect, kills held bundle
//   wb_sc_*, wb_vec_*, wb_nz_valid  writeback retire notifications
//   out_valid/out_ready/out_pc      execute side handshake and PC
//   MemoryWrite..Illegal            decoded execute controls
//   hazard_stall                    offered instruction blocked by a hazard
// ----------------------------------------------------------------------------
module decode_stage_piped
  import asip_isa_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int PC_W     = 8,
  parameter int NZ_CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  input  logic              wb_sc_valid,
  input  logic [REG_AW-1:0] wb_sc_reg,
  input  logic              wb_vec_valid,
  input  logic [REG_AW-1:0] wb_vec_reg,
  input  logic              wb_nz_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              MemoryWrite,
  output logic [1:0]        WriteRegFrom,
  output logic [REG_AW-1:0] RegToWrite,
  output logic [REG_AW-1:0] RegSrcA,
  output logic [REG_AW-1:0] RegSrcB,
  output logic [7:0]        Immediate,
  output logic              RegWriteEnSc,
  output logic              RegWriteEnVec,
  output logic              OverWriteNz,
  output logic [2:0]        PcWriteEn,
  output logic [2:0]        AluOpCode,
  output logic              Illegal,
  output logic              hazard_stall
);

  localparam int NREG = 2 ** REG_AW;

  // A register is busy if its scoreboard bit is set or the bundle sitting in
  // the output register (not yet counted in the scoreboard) writes it.
  function automatic logic regBusy(input logic [NREG-1:0]   pend,
                                   input logic              occWrites,
                                   input logic [REG_AW-1:0] occDst,
                                   input logic [REG_AW-1:0] r);
    return pend[r] || (occWrites && (occDst == r));
  endfunction

  // Saturating up/down step; simultaneous up and down cancel.
  function automatic logic [NZ_CNT_W-1:0] nzStep(input logic [NZ_CNT_W-1:0] cnt,
                                                 input logic up,
                                                 input logic down);
    logic [NZ_CNT_W-1:0] nxt;
    nxt = cnt;
    if (up && !down && (cnt != '1))     nxt = cnt + NZ_CNT_W'(1);
    else if (down && !up && (cnt != '0)) nxt = cnt - NZ_CNT_W'(1);
    return nxt;
  endfunction

  decodeT              dec_p0;
  srcUseT              use_p0;
  logic [REG_AW-1:0]   srcA_p0;
  logic [REG_AW-1:0]   srcB_p0;
  logic [REG_AW-1:0]   dst_p0;

  decodeT              bundle_p1;
  logic [PC_W-1:0]     pc_p1;
  logic                vld_p1;
  logic [REG_AW-1:0]   occDst;
  logic                occSc;
  logic                occVec;

  logic [NREG-1:0]     pendSc;
  logic [NREG-1:0]     pendVec;
  logic [NZ_CNT_W-1:0] nzCnt;

  logic                scHazard;
  logic                vecHazard;
  logic                nzHazard;
  logic                accept;
  logic                issue;

  // ---- stage p0: combinational decode and hazard detection ----
  assign dec_p0  = decodeInstr(in_instr);
  assign use_p0  = decodeSrcUse(in_instr[15:12]);
  assign srcA_p0 = REG_AW'(dec_p0.regSrcA);
  assign srcB_p0 = REG_AW'(dec_p0.regSrcB);
  assign dst_p0  = REG_AW'(dec_p0.regToWrite);

  assign occDst = REG_AW'(bundle_p1.regToWrite);
  assign occSc  = vld_p1 && bundle_p1.regWriteEnSc;
  assign occVec = vld_p1 && bundle_p1.regWriteEnVec;

  assign scHazard =
      (use_p0.scA          && regBusy(pendSc, occSc, occDst, srcA_p0)) ||
      (use_p0.scB          && regBusy(pendSc, occSc, occDst, srcB_p0)) ||
      (dec_p0.regWriteEnSc && regBusy(pendSc, occSc, occDst, dst_p0));

  assign vecHazard =
      (use_p0.vecA          && regBusy(pendVec, occVec, occDst, srcA_p0)) ||
      (use_p0.vecB          && regBusy(pendVec, occVec, occDst, srcB_p0)) ||
      (dec_p0.regWriteEnVec && regBusy(pendVec, occVec, occDst, dst_p0));

  // Conditional branches need a settled NZ flag: nothing in execute and
  // nothing waiting in the output register may still update it.
  assign nzHazard =
      ((dec_p0.pcWriteEn == PCW_JE) || (dec_p0.pcWriteEn == PCW_JNE)) &&
      ((nzCnt != '0) || (vld_p1 && bundle_p1.overWriteNz));

  assign hazard_stall = rst_n && in_valid && (scHazard || vecHazard || nzHazard);
  assign in_ready     = rst_n && !hazard_stall && (!vld_p1 || out_ready) && !flush;
  assign accept       = in_valid && in_ready;
  // A bundle killed by flush in the same cycle never reaches execute.
  assign issue        = vld_p1 && out_ready && !flush;

  // ---- stage p1: ID/EX output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
      pc_p1     <= '0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (accept)    vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
      if (accept) begin
        bundle_p1 <= dec_p0;
        pc_p1     <= in_pc;
      end
    end
  end

  // Pending-writer tracking, updated when the bundle leaves for execute.
  reg_scoreboard #(.REG_AW(REG_AW)) u_scSb (
    .clk     (clk),
    .rst_n   (rst_n),
    .setEn   (issue && bundle_p1.regWriteEnSc),
    .setReg  (occDst),
    .clrEn   (wb_sc_valid),
    .clrReg  (wb_sc_reg),
    .pending (pendSc)
  );

  reg_scoreboard #(.REG_AW(REG_AW)) u_vecSb (
    .clk     (clk),
    .rst_n   (rst_n),
    .setEn   (issue && bundle_p1.regWriteEnVec),
    .setReg  (occDst),
    .clrEn   (wb_vec_valid),
    .clrReg  (wb_vec_reg),
    .pending (pendVec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) nzCnt <= '0;
    else        nzCnt <= nzStep(nzCnt, issue && bundle_p1.overWriteNz, wb_nz_valid);
  end

  assign out_valid     = vld_p1;
  assign out_pc        = pc_p1;
  assign MemoryWrite   = bundle_p1.memoryWrite;
  assign WriteRegFrom  = bundle_p1.writeRegFrom;
  assign RegToWrite    = occDst;
  assign RegSrcA       = REG_AW'(bundle_p1.regSrcA);
  assign RegSrcB       = REG_AW'(bundle_p1.regSrcB);
  assign Immediate     = bundle_p1.immediate;
  assign RegWriteEnSc  = bundle_p1.regWriteEnSc;
  assign RegWriteEnVec = bundle_p1.regWriteEnVec;
  assign OverWriteNz   = bundle_p1.overWriteNz;
  assign PcWriteEn     = bundle_p1.pcWriteEn;
  assign AluOpCode     = bundle_p1.aluOpCode;
  assign Illegal       = bundle_p1.illegal;

endmodule

// File: doc/decode_stage_piped.md
Name: decode_stage_piped

Overview:
- Registered successor to the combinational decoder stage of the vector ASIP.
- Decodes one 16-bit instruction per cycle into execute-stage controls. The decoded result is held in an ID/EX output register with a valid/ready handshake.
- A scalar/vector scoreboard and an NZ-flag in-flight counter produce hazard stalls. Flush support kills wrong-path instructions.
- Sits between fetch and execute; writeback ports release scoreboard entries.

Parameters:
- REG_AW, 4, register-index width for scalar and vector files (2**REG_AW regs each)
- PC_W, 8, width of carried PC
- NZ_CNT_W, 3, width of in-flight NZ-writer counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  fetch has instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  16  instruction
- in_pc  in  PC_W  instruction PC
- flush  in  1  execute redirect; kill held instruction
- wb_sc_valid / wb_sc_reg  in  1 / REG_AW  scalar writeback retire
- wb_vec_valid / wb_vec_reg  in  1 / REG_AW  vector writeback retire
- wb_nz_valid  in  1  an NZ-writing instruction retired
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  PC_W  carried PC
- MemoryWrite  out  1  store
- WriteRegFrom  out  2  0=mem, 1=ALU, 2=immediate
- RegToWrite  out  REG_AW  destination
- RegSrcA / RegSrcB  out  REG_AW  instr[11:8] / instr[7:4]
- Immediate  out  8  instr[7:0]
- RegWriteEnSc / RegWriteEnVec  out  1  write enables
- OverWriteNz  out  1  updates NZ flag
- PcWriteEn  out  3  100=jmp, 010=je, 001=jne
- AluOpCode  out  3  ALU operation
- Illegal  out  1  undefined opcode
- hazard_stall  out  1  in_valid held off by hazard

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0; all decoded outputs 0; scoreboard cleared; nz counter 0. in_ready and hazard_stall are 0 during reset.
- Opcode = instr[15:12]. RegToWrite is instr[11:8] wherever it applies.
- 0x0 losc: scalar write, WriteRegFrom=2.
- 0x1..0x6 (xor, add, sub, mul, rshf, lshf): AluOpCode=opcode, vector write, WriteRegFrom=1, OverWriteNz=1.
- 0x7 inc: AluOpCode=7, scalar write, WriteRegFrom=1, OverWriteNz=1.
- 0x8 je, 0x9 jne, 0xA jmp: branch; PcWriteEn per port encoding.
- 0xC svpix: MemoryWrite=1.
- 0xD lopix: vector write, WriteRegFrom=0.
- 0xF lmem: scalar write, WriteRegFrom=0.
- 0xB, 0xE: Illegal=1, all enables 0, passed downstream.
- Immediate always instr[7:0].
- Latency: instruction accepted at edge N appears on outputs after edge N (one cycle).
- Hazard: assert hazard_stall when in_valid=1 and any of the following holds:
  - a used source or destination is pending in its file's scoreboard;
  - it matches the dest of the valid output-register occupant in the same file;
  - the instruction is je/jne while the nz counter is nonzero or the occupant has OverWriteNz=1.
- in_ready = !hazard_stall && (!out_valid || out_ready) && !flush.
- Scoreboard set occurs on output handshake (out_valid && out_ready) for the issued dest in its file.
- Scoreboard clear occurs on wb_*_valid for wb_*_reg.
- Same-cycle set and clear of the same register: set wins.
- nz counter: +1 on issue with OverWriteNz, -1 on wb_nz_valid. Simultaneous increment and decrement leave it unchanged. Saturates at max; never wraps below 0.
- flush: out_valid cleared next edge; input not accepted that cycle; scoreboard and counter unaffected (flushed instruction never issued). Writebacks in the flush cycle still apply.
- Output register holds stable while out_valid && !out_ready.
- Reset mid-stall drops the held instruction and all pending state.

Decomposition:
- Package asip_isa_pkg holds opcode localparams (OP_LOSC..OP_LMEM), the WriteRegFrom enum, and the PcWriteEn constants.
- Sub-module reg_scoreboard (parametrised by REG_AW) is instantiated twice, scalar and vector.
- The combinational decode is a function in the package.

Test Plan:
- Reset, then 0xF510 with out_ready=1 -> next cycle out_valid=1, RegToWrite=5, Immediate=16, RegWriteEnSc=1, WriteRegFrom=0; sc[5] pending after issue.
- lmem 0xF510 issued, then losc 0x0512 reading/writing r5 -> hazard_stall=1, in_ready=0 until wb_sc_valid with reg 5; accepted the following cycle.
- 0x2190 (add) issued, then je 0x8010 -> stalled until wb_nz_valid; then PcWriteEn=010, Immediate=16.
- Backpressure: 0x3260 with out_ready=0 for 3 cycles -> outputs stable, AluOpCode=3, in_ready=0; released in the cycle out_ready=1.
- flush while 0x9032 held -> out_valid=0 next cycle; no scoreboard/counter change.
- 0xB000 -> Illegal=1, all write enables 0, PcWriteEn=0; 0x7E00 -> AluOpCode=7, RegToWrite=14, RegWriteEnSc=1.
